serial_adder: RTL and testbench

- Bit-serial N-bit adder built around a single 1-bit full-adder cell plus a registered carry.
- Accepts one operand pair through a valid/ready input handshake and processes one bit per clock, LSB first.
- Presents the WIDTH-bit sum and carry-out through a valid/ready output handshake.
- Area-cheap alternative to the ripple-carry adders, for arithmetic paths that are not throughput-critical.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/fulladder_HA.sv | 18 +
 rtl/serial_adder.sv | 97 +++++++++
 tb/tb_serial_adder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding and default width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int ADD_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/fulladder_HA.sv
// 1-bit full adder cell built from two half adders; purely combinational.
module fulladder_HA (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1, c1, c2;

  assign s1   = a ^ b;
  assign c1   = a & b;
  assign s    = s1 ^ cin;
  assign c2   = s1 & cin;
  assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, registered carry, LSB-first,
// valid/ready on both the operand and the result side.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = ADD_WIDTH_DEFAULT,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] ra_reg;
  logic [WIDTH-1:0] rb_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_next;
  logic             carry_reg;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last_bit;

  fulladder_HA u_fa (
    .a   (ra_reg[0]),
    .b   (rb_reg[0]),
    .cin (carry_reg),
    .s   (fa_s),
    .cout(fa_c)
  );

  // New sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_next = fa_s;
    end else begin : g_sum_wn
      assign sum_next = {fa_s, sum_reg[WIDTH-1:1]};
    end
  endgenerate

  // HOLD can take a new pair on the same edge the result leaves, so no bubble.
  assign in_ready  = (state_reg == IDLE) || ((state_reg == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_bit  = (cnt_reg == CNT_W'(WIDTH - 1));

  assign out_valid = (state_reg == HOLD);
  assign sum       = sum_reg;
  assign cout      = carry_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ra_reg    <= '0;
      rb_reg    <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, HOLD: begin
          if (accept) begin
            ra_reg    <= a;
            rb_reg    <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            state_reg <= RUN;
          end else if ((state_reg == HOLD) && out_ready) begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= fa_c;
          ra_reg    <= ra_reg >> 1;
          rb_reg    <= rb_reg >> 1;
          cnt_reg   <= cnt_reg + 1'b1;
          if (last_bit) begin
            state_reg <= HOLD;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] sum;
  logic       cout;

  logic       w1_in_valid = 1'b0;
  logic       w1_out_ready = 1'b1;
  logic [0:0] w1_a = '0;
  logic [0:0] w1_b = '0;
  logic       w1_cin = 1'b0;
  logic       w1_in_ready;
  logic       w1_out_valid;
  logic [0:0] w1_sum;
  logic       w1_cout;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic s;
    logic co;
  } vec1_t;

  vec_t  vecs[10];
  vec1_t vecs1[8];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (w1_in_valid),
    .in_ready (w1_in_ready),
    .a        (w1_a),
    .b        (w1_b),
    .cin      (w1_cin),
    .out_valid(w1_out_valid),
    .out_ready(w1_out_ready),
    .sum      (w1_sum),
    .cout     (w1_cout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for out_valid on the WIDTH=8 instance; returns cycles waited and in_ready-low count.
  task automatic wait_valid8(output int n, output int low);
    n = 0;
    low = 0;
    while (!out_valid && n < 50) begin
      if (!in_ready) low++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_op8(input vec_t v);
    int n;
    int low;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1; out_ready = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~v.a; b = ~v.b; cin = ~v.cin;
    wait_valid8(n, low);
    check("latency8", n, 8);
    check("in_ready_low_cycles", low, 8);
    check("sum8", sum, v.s);
    check("cout8", cout, v.co);
    $display("op a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d latency=%0d",
             v.a, v.b, v.cin, sum, cout, n);
    @(posedge clk);
    #1;
    check("out_valid_drop", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int low;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[8] = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0};
    vecs[9] = '{8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1};

    vecs1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_w1_out_valid", w1_out_valid, 0);
    check("rst_w1_in_ready", w1_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op8(vecs[i]);
    end

    // Backpressure: result must stay put and inputs be ignored while out_ready=0
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid8(n, low);
    check("bp_latency", n, 8);
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      check("bp_out_valid", out_valid, 1);
      check("bp_sum", sum, 8'h30);
      check("bp_cout", cout, 0);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    check("bp_sum_after", sum, 8'h30);
    $display("backpressure a=10 b=20 -> sum=%02h cout=%0d held 5 cycles", sum, cout);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", out_valid, 0);

    // Back-to-back: transfer and accept on the same edge
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid8(n, low);
    check("b2b_first_sum", sum, 8'h96);
    a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = 1'b1;
    check("b2b_in_ready_hold", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_no_bubble", in_ready, 0);
    wait_valid8(n, low);
    check("b2b_latency", n, 8);
    check("b2b_sum", sum, 8'h03);
    check("b2b_cout", cout, 0);
    $display("back-to-back second a=01 b=02 -> sum=%02h cout=%0d latency=%0d", sum, cout, n);
    @(posedge clk);
    #1;

    // Reset mid-RUN, then a normal operation
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_in_ready", in_ready, 1);
    $display("reset mid-run -> out_valid=%0d in_ready=%0d", out_valid, in_ready);
    @(negedge clk);
    rst_n = 1'b1;
    run_op8(vecs[7]);

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      int m;
      @(negedge clk);
      w1_a = vecs1[i].a; w1_b = vecs1[i].b; w1_cin = vecs1[i].cin;
      w1_in_valid = 1'b1; w1_out_ready = 1'b1;
      @(posedge clk);
      #1;
      w1_in_valid = 1'b0;
      m = 0;
      while (!w1_out_valid && m < 20) begin
        @(posedge clk);
        #1;
        m++;
      end
      check("w1_latency", m, 1);
      check("w1_sum", w1_sum, vecs1[i].s);
      check("w1_cout", w1_cout, vecs1[i].co);
      $display("w1 a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d latency=%0d",
               vecs1[i].a, vecs1[i].b, vecs1[i].cin, w1_sum, w1_cout, m);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
